// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles DATA_WIDTH-bit words from a
// gated serial stream with a one-deep valid/ready output register.
module serial_to_parallel #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_enable,
  input  logic                          serial_in,
  input  logic                          rx_ready,
  input  logic                          overrun_clr,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_valid,
  output logic                          overrun,
  output logic                          frame_err,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  complete;
  logic                  load;
  logic                  drop;
  logic                  accept;
  logic                  abort;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_nxt = {shreg[DATA_WIDTH-2:0], serial_in};
    end else begin : g_lsb
      assign shift_nxt = {serial_in, shreg[DATA_WIDTH-1:1]};
    end
  endgenerate

  // The completing edge hands shift_nxt straight to rx_data.
  always_comb begin
    complete = rx_enable && (bit_count == LAST);
    load     = complete && (!rx_valid || rx_ready);
    drop     = complete && rx_valid && !rx_ready;
    accept   = !complete && rx_valid && rx_ready;
    abort    = (state == SHIFT) && !rx_enable && (bit_count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_count <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= rx_enable ? SHIFT : IDLE;
      frame_err <= abort;
      if (complete) begin
        shreg     <= '0;
        bit_count <= '0;
      end else if (rx_enable) begin
        shreg     <= shift_nxt;
        bit_count <= bit_count + 1'b1;
      end else begin
        shreg     <= '0;
        bit_count <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        load: begin
          rx_data  <= shift_nxt;
          rx_valid <= 1'b1;
        end
        accept: rx_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in rx_data[DATA_WIDTH-1]; 0 = first bit lands in rx_data[0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_enable  input  1  frame-active qualifier from the upstream serializer; high while serial_in carries valid bits.
REQ-006 serial_in  input  1  serial data; one bit sampled per clk edge while rx_enable=1.
REQ-007 rx_ready  input  1  consumer accepts rx_data on an edge where rx_valid=1 and rx_ready=1.
REQ-008 overrun_clr  input  1  clears the sticky overrun flag.
REQ-009 rx_data  output  DATA_WIDTH  last completed word; registered.
REQ-010 rx_valid  output  1  rx_data holds an unaccepted word.
REQ-011 overrun  output  1  sticky; a completed word was dropped.
REQ-012 frame_err  output  1  one-cycle pulse; frame ended mid-word.
REQ-013 bit_count  output  clog2(DATA_WIDTH)  bits of the current partial word received so far.

Function
REQ-014 States: IDLE (rx_enable=0, bit_count=0) and SHIFT (rx_enable=1); IDLE->SHIFT on any edge with rx_enable=1; SHIFT->IDLE on any edge with rx_enable=0.
REQ-015 Sampling: every edge with rx_enable=1 shifts serial_in into the internal shift register and increments bit_count, including the IDLE->SHIFT edge.
REQ-016 Shift direction: MSB_FIRST=1 shifts left with new bit at LSB; MSB_FIRST=0 shifts right with new bit at MSB.
REQ-017 Completion: the edge sampling bit DATA_WIDTH resets bit_count to 0 and produces the full word (including that bit), with zero additional latency.
REQ-018 Load rule: on completion, when rx_valid=0 or rx_ready=1 on that edge, rx_data loads the word and rx_valid is 1 after the edge.
REQ-019 Overrun: on completion, when rx_valid=1 and rx_ready=0, the new word is discarded, rx_data is unchanged, rx_valid stays 1, and overrun sets.
REQ-020 Accept: an edge with rx_valid=1, rx_ready=1 and no completion clears rx_valid; rx_data holds its value.
REQ-021 overrun clears only on an edge with overrun_clr=1; when set and clear occur on the same edge, set wins.
REQ-022 Back-to-back: rx_enable held high across words shall not cause a gap; the edge after completion samples bit 1 of the next word.
REQ-023 Abort: rx_enable=0 with bit_count in 1..DATA_WIDTH-1 shall discard the partial word, zero bit_count, and pulse frame_err for exactly one cycle.
REQ-024 rx_enable=0 with bit_count=0 shall not raise frame_err.
REQ-025 rx_valid and rx_data are unaffected by rx_enable and abort; a pending word stays until accepted.
REQ-026 rx_ready with rx_valid=0 has no effect.

Reset
REQ-027 rst_n=0 forces, asynchronously: state IDLE, shift register 0, bit_count 0, rx_data 0, rx_valid 0, overrun 0, frame_err 0.
REQ-028 Reset mid-word shall discard the partial word; no frame_err is produced on reset.
REQ-029 After rst_n deasserts, the first edge with rx_enable=1 samples bit 1 of a new word.

Verification
REQ-030 Defaults, rx_ready=1, rx_enable high 8 cycles, serial_in 1,0,1,0,0,1,0,1 -> rx_data=0xA5, rx_valid=1 right after 8th edge, low one edge later.
REQ-031 MSB_FIRST=0, same bits -> rx_data=0xA5 (bit0 first: 1,0,1,0,0,1,0,1 = 0xA5); bits 0,0,0,0,1,1,1,1 -> 0xF0.
REQ-032 rx_ready=0, two back-to-back words 0x3C then 0xC3 over 16 edges -> rx_data stays 0x3C, overrun=1 after edge 16; overrun_clr pulse -> overrun=0.
REQ-033 rx_ready=1 on the completion edge of a second word while first is pending -> rx_data=2nd word, rx_valid=1, overrun=0.
REQ-034 rx_enable drops after 5 bits -> frame_err one-cycle pulse, bit_count=0, rx_valid unchanged; next full frame 0x81 received correctly.
REQ-035 rst_n low after 4 bits of a frame -> all outputs 0 immediately, no frame_err; subsequent frame 0x5A -> rx_data=0x5A.
